// File: rtl/tt09_um_rishabhrkaushik_serial_sub.sv
// Bit-serial 8-bit subtractor: uo_out = (A - B) mod 256, computed LSB first,
// one bit per cycle, with busy/done/borrow status on uio_out[6:4].
// A start request is registered for one cycle before the shift begins.
// The datapath therefore spends exactly 8 cycles in SHIFT, and done appears
// in the cycle following the ninth edge after start was sampled.
// Optional zero flag on uio_out[7]: define TT09_SERIAL_SUB_ZERO_FLAG_EN.
module tt09_um_rishabhrkaushik_serial_sub (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [7:0]  r_wa;
   logic [7:0]  r_wb;
   logic [7:0]  r_res;
   logic [2:0]  r_cnt;
   logic        r_br;
   logic        r_start_pend;

   logic        w_load_a;
   logic        w_load_b;
   logic        w_start;
   logic        w_start_ok;
   logic        w_busy;
   logic        w_done;
   logic        w_zero;
   logic        w_d;
   logic        w_br_next;
   logic [4:0]  w_unused_bits;

   assign w_load_a      = uio_in[0];
   assign w_load_b      = uio_in[1];
   assign w_start       = uio_in[2];
   assign w_unused_bits = uio_in[7:3];

   // A start sampled together with a load strobe is dropped; the load wins.
   assign w_start_ok = (r_state == StIdle) && w_start && !w_load_a && !w_load_b;

   // Full-subtractor bit on the LSBs of the working copies.
   assign w_d       = r_wa[0] ^ r_wb[0] ^ r_br;
   assign w_br_next = (~r_wa[0] & r_wb[0]) | (~(r_wa[0] ^ r_wb[0]) & r_br);

   // Next-state and status decode.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_start_pend) w_state_next = StShift;
         end
         StShift: begin
            w_busy = 1'b1;
            if (r_cnt == 3'd7) w_state_next = StDone;
         end
         StDone: begin
            w_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State, operands, working copies and result; everything freezes while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_a          <= 8'd0;
         r_b          <= 8'd0;
         r_wa         <= 8'd0;
         r_wb         <= 8'd0;
         r_res        <= 8'd0;
         r_cnt        <= 3'd0;
         r_br         <= 1'b0;
         r_start_pend <= 1'b0;
      end else if (ena) begin
         r_state      <= w_state_next;
         r_start_pend <= w_start_ok && !r_start_pend;
         unique case (r_state)
            StIdle: begin
               if (w_load_a) r_a <= ui_in;
               if (w_load_b) r_b <= ui_in;
               // Shift starts from the stored operands so A and B survive the operation.
               if (r_start_pend) begin
                  r_wa  <= r_a;
                  r_wb  <= r_b;
                  r_cnt <= 3'd0;
                  r_br  <= 1'b0;
               end
            end
            StShift: begin
               r_res <= {w_d, r_res[7:1]};
               r_wa  <= {1'b0, r_wa[7:1]};
               r_wb  <= {1'b0, r_wb[7:1]};
               r_br  <= w_br_next;
               r_cnt <= r_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef TT09_SERIAL_SUB_ZERO_FLAG_EN
   logic r_valid;

   // Remembers that at least one operation has completed since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (ena && (r_state == StShift) && (r_cnt == 3'd7)) begin
         r_valid <= 1'b1;
      end
   end

   assign w_zero = r_valid && ((r_state == StDone) || (r_state == StIdle)) && (r_res == 8'd0);
`else
   assign w_zero = 1'b0;
`endif

   assign uo_out  = r_res;
   assign uio_out = {w_zero, r_br, w_done, w_busy, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt09_um_rishabhrkaushik_serial_sub.sv
// Directed bench for the bit-serial subtractor: a vector table of operand
// pairs plus hand-written sequences for ignored strobes, ena gating,
// mid-operation reset and start/load collisions.
module tb_tt09_um_rishabhrkaushik_serial_sub;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic busy, done, borrow, zero;
   assign busy   = uio_out[4];
   assign done   = uio_out[5];
   assign borrow = uio_out[6];
   assign zero   = uio_out[7];

   int n_checks = 0;
   int n_errors = 0;

   tt09_um_rishabhrkaushik_serial_sub dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       br;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
      ui_in  = a;
      uio_in = 8'h01;
      tick();
      ui_in  = b;
      uio_in = 8'h02;
      tick();
      uio_in = 8'h00;
   endtask

   // kind 0: plain; 1: load_a+start strobe with ui_in=0 at shift cycle 3;
   // 2: ena dropped for 5 cycles at shift cycle 3.
   task automatic run_op(input logic [7:0] er, input logic eb, input int kind, input string nm);
      int   n;
      int   busy_n;
      logic [7:0] snap;
      logic exp_z;
`ifdef TT09_SERIAL_SUB_ZERO_FLAG_EN
      exp_z = (er == 8'h00);
`else
      exp_z = 1'b0;
`endif
      // Upper control bits set to show they are ignored.
      uio_in = 8'hAC;
      tick();
      uio_in = 8'h00;
      chk({nm, " busy before shift"}, {31'd0, busy}, 32'd0);
      n = 0;
      busy_n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (done) break;
         if (busy) busy_n++;
         if (kind == 1) begin
            uio_in = (n == 3) ? 8'h05 : 8'h00;
            ui_in  = 8'h00;
         end
         if (kind == 2 && n == 3) begin
            snap = uo_out;
            ena  = 1'b0;
            uio_in = 8'h07;
            repeat (5) begin
               tick();
               chk({nm, " gated busy"}, {31'd0, busy}, 32'd1);
               chk({nm, " gated result"}, {24'd0, uo_out}, {24'd0, snap});
            end
            uio_in = 8'h00;
            ena = 1'b1;
         end
      end
      uio_in = 8'h00;
      chk({nm, " latency"}, n, 32'd9);
      chk({nm, " busy cycles"}, busy_n, 32'd8);
      chk({nm, " result"}, {24'd0, uo_out}, {24'd0, er});
      chk({nm, " borrow"}, {31'd0, borrow}, {31'd0, eb});
      chk({nm, " busy at done"}, {31'd0, busy}, 32'd0);
      chk({nm, " zero"}, {31'd0, zero}, {31'd0, exp_z});
      chk({nm, " low nibble"}, {28'd0, uio_out[3:0]}, 32'd0);
      tick();
      chk({nm, " done one cycle"}, {31'd0, done}, 32'd0);
      chk({nm, " idle busy"}, {31'd0, busy}, 32'd0);
      chk({nm, " result hold"}, {24'd0, uo_out}, {24'd0, er});
      chk({nm, " borrow hold"}, {31'd0, borrow}, {31'd0, eb});
   endtask

   initial begin
      vecs[0] = '{a: 8'h2A, b: 8'h0F, res: 8'h1B, br: 1'b0};
      vecs[1] = '{a: 8'h05, b: 8'h07, res: 8'hFE, br: 1'b1};
      vecs[2] = '{a: 8'h00, b: 8'h00, res: 8'h00, br: 1'b0};
      vecs[3] = '{a: 8'hFF, b: 8'h01, res: 8'hFE, br: 1'b0};
      vecs[4] = '{a: 8'h00, b: 8'h01, res: 8'hFF, br: 1'b1};
      vecs[5] = '{a: 8'h80, b: 8'h01, res: 8'h7F, br: 1'b0};
      vecs[6] = '{a: 8'h01, b: 8'h80, res: 8'h81, br: 1'b1};
      vecs[7] = '{a: 8'hFF, b: 8'hFF, res: 8'h00, br: 1'b0};
      vecs[8] = '{a: 8'h7F, b: 8'h80, res: 8'hFF, br: 1'b1};
      vecs[9] = '{a: 8'h10, b: 8'h10, res: 8'h00, br: 1'b0};

      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      #23;
      chk("reset uo_out", {24'd0, uo_out}, 32'd0);
      chk("reset uio_out", {24'd0, uio_out}, 32'd0);
      chk("reset uio_oe", {24'd0, uio_oe}, 32'h0F0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         load_ab(vecs[i].a, vecs[i].b);
         run_op(vecs[i].res, vecs[i].br, 0, $sformatf("vec%0d", i));
      end

      // Strobes during SHIFT must not disturb the operation or stored A.
      load_ab(8'hFF, 8'h01);
      run_op(8'hFE, 1'b0, 1, "strobe in shift");
      run_op(8'hFE, 1'b0, 0, "repeat start");

      // ena low freezes everything, including a pending start.
      load_ab(8'h20, 8'h01);
      ena = 1'b0;
      uio_in = 8'h04;
      repeat (3) tick();
      chk("ena low start ignored", {31'd0, busy}, 32'd0);
      uio_in = 8'h00;
      ena = 1'b1;
      tick();
      chk("ena restore idle", {31'd0, busy}, 32'd0);
      run_op(8'h1F, 1'b0, 2, "ena gap");

      // Asynchronous reset in the middle of a shift.
      load_ab(8'h80, 8'h01);
      uio_in = 8'h04;
      tick();
      uio_in = 8'h00;
      repeat (4) tick();
      chk("busy before reset", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset uo_out", {24'd0, uo_out}, 32'd0);
      chk("async reset uio_out", {24'd0, uio_out}, 32'd0);
      chk("async reset uio_oe", {24'd0, uio_oe}, 32'h0F0);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      run_op(8'h00, 1'b0, 0, "after reset A=B=0");
      load_ab(8'h10, 8'h10);
      run_op(8'h00, 1'b0, 0, "after reset 10-10");

      // Start together with load_b: load taken, start dropped.
      ui_in  = 8'h10;
      uio_in = 8'h01;
      tick();
      ui_in  = 8'h03;
      uio_in = 8'h06;
      tick();
      uio_in = 8'h00;
      begin
         int seen;
         seen = 0;
         repeat (4) begin
            tick();
            if (busy || done) seen++;
         end
         chk("start with load no busy", seen, 32'd0);
      end
      run_op(8'h0D, 1'b0, 0, "new B");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
